ring_phase_monitor: RTL and testbench

//  Downstream checker/decoder for the one-hot ring_counter output.
//  - Tracks the rotation and locks onto a clean sequence.
//  - Encodes the hot position to a binary phase and counts completed revolutions.
//  - Flags and counts sequence faults such as lost, duplicated or skipped tokens.
//  - Sits between ring_counter.out and the phase-sequenced logic it drives.

---
 rtl/ring_phase_monitor.sv | 189 ++++++++++++++++++
 tb/tb_ring_phase_monitor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_phase_monitor.sv
// Checker/decoder for a one-hot rotating ring: locks onto a clean rotation,
// reports the hot-bit phase, counts revolutions and flags/counts sequence faults.
module ring_phase_monitor #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int REV_W      = 8,
  parameter int ERR_W      = 8,
  localparam int PW        = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             clear_err,
  output logic             locked,
  output logic [PW-1:0]    phase,
  output logic             wrap_pulse,
  output logic [REV_W-1:0] rev_count,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count
);

  localparam int CW = $clog2(LOCK_COUNT + 1);

  localparam logic [WIDTH-1:0] RING_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] RING_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_LOCK  = CW'(LOCK_COUNT);
  localparam logic [REV_W-1:0] REV_ONE   = {{(REV_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ZERO  = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0] ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != RING_ZERO) && ((v & (v - RING_ONE)) == RING_ZERO);
  endfunction

  function automatic logic [PW-1:0] hot_index(input logic [WIDTH-1:0] v);
    logic [PW-1:0] idx;
    idx = {PW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        idx = PW'(i);
      end
    end
    return idx;
  endfunction

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   prev_r;
  logic [WIDTH-1:0]   prev_s;
  logic [CW-1:0]      lock_cnt_r;
  logic [CW-1:0]      lock_cnt_s;
  logic [CW-1:0]      lock_inc_s;
  logic [PW-1:0]      phase_s;
  logic               valid_s;
  logic               adv_s;
  logic               wrap_s;
  logic               wrap_pulse_s;
  logic [REV_W-1:0]   rev_count_s;
  logic               err_pulse_s;
  logic               err_sticky_s;
  logic [ERR_W-1:0]   err_base_s;
  logic [ERR_W-1:0]   err_count_s;

  // Sample classification against the previously accepted token.
  always_comb begin
    valid_s    = is_onehot(ring_in);
    adv_s      = valid_s && (ring_in == {prev_r[WIDTH-2:0], prev_r[WIDTH-1]});
    wrap_s     = adv_s && prev_r[WIDTH-1];
    lock_inc_s = lock_cnt_r + CNT_ONE;
    if (valid_s) begin
      prev_s  = ring_in;
      phase_s = hot_index(ring_in);
    end else begin
      prev_s  = prev_r;
      phase_s = phase;
    end
  end

  // Next-state and output decode; a clear is applied before a same-edge fault.
  always_comb begin
    state_s      = state_r;
    lock_cnt_s   = lock_cnt_r;
    wrap_pulse_s = 1'b0;
    rev_count_s  = rev_count;
    err_pulse_s  = 1'b0;

    if (clear_err) begin
      err_base_s   = ERR_ZERO;
      err_sticky_s = 1'b0;
    end else begin
      err_base_s   = err_count;
      err_sticky_s = err_sticky;
    end
    err_count_s = err_base_s;

    case (state_r)
      ST_SEARCH: begin
        if (valid_s) begin
          state_s    = ST_LOCKING;
          lock_cnt_s = CNT_ZERO;
        end else begin
          state_s    = ST_SEARCH;
        end
      end
      ST_LOCKING: begin
        if (adv_s) begin
          if (lock_inc_s == CNT_LOCK) begin
            state_s    = ST_LOCKED;
            lock_cnt_s = CNT_ZERO;
          end else begin
            lock_cnt_s = lock_inc_s;
          end
        end else if (valid_s) begin
          lock_cnt_s = CNT_ZERO;
        end else begin
          state_s    = ST_SEARCH;
          lock_cnt_s = CNT_ZERO;
        end
      end
      ST_LOCKED: begin
        if (adv_s) begin
          if (wrap_s) begin
            wrap_pulse_s = 1'b1;
            rev_count_s  = rev_count + REV_ONE;
          end else begin
            rev_count_s  = rev_count;
          end
        end else begin
          state_s      = ST_FAULT;
          err_pulse_s  = 1'b1;
          err_sticky_s = 1'b1;
          if (err_base_s != ERR_MAX) begin
            err_count_s = err_base_s + ERR_ONE;
          end else begin
            err_count_s = err_base_s;
          end
        end
      end
      ST_FAULT: begin
        // The sample seen here is never judged; resynchronise from scratch.
        state_s    = ST_SEARCH;
        lock_cnt_s = CNT_ZERO;
      end
      default: begin
        state_s    = ST_SEARCH;
        lock_cnt_s = CNT_ZERO;
      end
    endcase
  end

  // State, tracking registers and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_SEARCH;
      prev_r     <= RING_ZERO;
      lock_cnt_r <= CNT_ZERO;
      locked     <= 1'b0;
      phase      <= {PW{1'b0}};
      wrap_pulse <= 1'b0;
      rev_count  <= {REV_W{1'b0}};
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= ERR_ZERO;
    end else begin
      state_r    <= state_s;
      prev_r     <= prev_s;
      lock_cnt_r <= lock_cnt_s;
      locked     <= (state_s == ST_LOCKED);
      phase      <= phase_s;
      wrap_pulse <= wrap_pulse_s;
      rev_count  <= rev_count_s;
      err_pulse  <= err_pulse_s;
      err_sticky <= err_sticky_s;
      err_count  <= err_count_s;
    end
  end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Self-checking bench for ring_phase_monitor: directed table, hand sequences
// for clear/reset/saturation corners, and random traffic against a token model.
module tb_ring_phase_monitor;

  localparam int W  = 4;
  localparam int LC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] ring = 4'b0000;

  logic       d_locked, d_wrap, d_errp, d_sticky;
  logic [1:0] d_phase;
  logic [7:0] d_rev, d_errc;
  logic       s_locked, s_wrap, s_errp, s_sticky;
  logic [1:0] s_phase;
  logic [7:0] s_rev;
  logic [1:0] s_errc;

  ring_phase_monitor #(.WIDTH(W), .LOCK_COUNT(LC), .REV_W(8), .ERR_W(8)) dut (
    .clock(clk), .reset(rst), .ring_in(ring), .clear_err(clr),
    .locked(d_locked), .phase(d_phase), .wrap_pulse(d_wrap), .rev_count(d_rev),
    .err_pulse(d_errp), .err_sticky(d_sticky), .err_count(d_errc));

  ring_phase_monitor #(.WIDTH(W), .LOCK_COUNT(LC), .REV_W(8), .ERR_W(2)) dut_sat (
    .clock(clk), .reset(rst), .ring_in(ring), .clear_err(clr),
    .locked(s_locked), .phase(s_phase), .wrap_pulse(s_wrap), .rev_count(s_rev),
    .err_pulse(s_errp), .err_sticky(s_sticky), .err_count(s_errc));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int sat_pulses = 0;

  // Token-level reference: which position holds the token, how long the
  // clean streak is, and whether we are locked / recovering from a fault.
  bit m_have_prev, m_tracking, m_lk, m_recover, m_sticky, m_wrap, m_errp;
  int m_pidx, m_phase, m_streak, m_rev, m_faults;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit c, input logic [3:0] v);
    int  idx;
    bit  one, adv;
    one = ($countones(v) == 1);
    idx = 0;
    for (int i = 0; i < W; i++) if (v[i]) idx = i;
    adv = one && m_have_prev && (idx == (m_pidx + 1) % W);
    m_wrap = 0;
    m_errp = 0;
    if (r) begin
      m_have_prev = 0; m_tracking = 0; m_lk = 0; m_recover = 0; m_sticky = 0;
      m_pidx = 0; m_phase = 0; m_streak = 0; m_rev = 0; m_faults = 0;
      return;
    end
    if (c) begin
      m_faults = 0;
      m_sticky = 0;
    end
    if (m_recover) begin
      m_recover = 0;
    end else if (m_lk) begin
      if (adv) begin
        if (m_pidx == W - 1) begin
          m_wrap = 1;
          m_rev = (m_rev + 1) % 256;
        end
      end else begin
        m_lk = 0; m_recover = 1; m_errp = 1; m_sticky = 1;
        m_faults++;
      end
    end else if (m_tracking) begin
      if (adv) begin
        m_streak++;
        if (m_streak == LC) begin
          m_lk = 1;
          m_tracking = 0;
        end
      end else if (one) begin
        m_streak = 0;
      end else begin
        m_tracking = 0;
      end
    end else if (one) begin
      m_tracking = 1;
      m_streak = 0;
    end
    if (one) begin
      m_have_prev = 1;
      m_pidx = idx;
      m_phase = idx;
    end
  endtask

  task automatic apply(input bit r, input bit c, input logic [3:0] v);
    @(negedge clk);
    rst = r;
    clr = c;
    ring = v;
    @(posedge clk);
    model_step(r, c, v);
    #1;
    chk("locked", d_locked, m_lk);
    chk("phase", d_phase, m_phase);
    chk("wrap_pulse", d_wrap, m_wrap);
    chk("rev_count", d_rev, m_rev);
    chk("err_pulse", d_errp, m_errp);
    chk("err_sticky", d_sticky, m_sticky);
    chk("err_count", d_errc, (m_faults > 255) ? 255 : m_faults);
    chk("sat_err_count", s_errc, (m_faults > 3) ? 3 : m_faults);
    chk("sat_err_pulse", s_errp, m_errp);
    if (s_errp === 1'b1) sat_pulses++;
  endtask

  typedef struct {
    logic       r;
    logic       c;
    logic [3:0] ring;
    logic       lk;
    logic [1:0] ph;
    logic [7:0] rev;
    logic [7:0] ec;
    logic       wp;
    logic       ep;
  } vec_t;

  function automatic vec_t mkv(logic r, logic c, logic [3:0] ri, logic lk, logic [1:0] ph,
                               logic [7:0] rv, logic [7:0] ec, logic wp, logic ep);
    vec_t t;
    t.r = r; t.c = c; t.ring = ri; t.lk = lk; t.ph = ph;
    t.rev = rv; t.ec = ec; t.wp = wp; t.ep = ep;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    int tok;
    int n;
    logic [3:0] v;
    bit rs, cl;

    // reset, lock-in, two revolutions, a 0110 fault, relock
    tbl.push_back(mkv(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b0001, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b0010, 1'b0, 2'd1, 8'd0, 8'd0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b0100, 1'b0, 2'd2, 8'd0, 8'd0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 8'd0, 8'd0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd1, 8'd0, 1'b1, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd1, 8'd0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 8'd1, 8'd0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 8'd1, 8'd0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd2, 8'd0, 1'b1, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd2, 8'd0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 8'd2, 8'd0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 8'd2, 8'd0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b0110, 1'b0, 2'd3, 8'd2, 8'd1, 1'b0, 1'b1));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b0001, 1'b0, 2'd0, 8'd2, 8'd1, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b0010, 1'b0, 2'd1, 8'd2, 8'd1, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b0100, 1'b0, 2'd2, 8'd2, 8'd1, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b1000, 1'b0, 2'd3, 8'd2, 8'd1, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd2, 8'd1, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd2, 8'd1, 1'b0, 1'b0));

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].c, tbl[i].ring);
      chk("tbl_locked", d_locked, tbl[i].lk);
      chk("tbl_phase", d_phase, tbl[i].ph);
      chk("tbl_rev", d_rev, tbl[i].rev);
      chk("tbl_errc", d_errc, tbl[i].ec);
      chk("tbl_wrap", d_wrap, tbl[i].wp);
      chk("tbl_errp", d_errp, tbl[i].ep);
    end
    chk("tbl_sticky", d_sticky, 1'b1);

    // all-zero input from reset never leaves SEARCH
    apply(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 10; i++) apply(1'b0, 1'b0, 4'b0000);
    chk("zero_locked", d_locked, 1'b0);
    chk("zero_errc", d_errc, 8'd0);
    chk("zero_phase", d_phase, 2'd0);

    // five faults: full counter reaches 5, 2-bit counter pins at 3
    apply(1'b1, 1'b0, 4'b0000);
    sat_pulses = 0;
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 1'b0, 4'b0001);
      apply(1'b0, 1'b0, 4'b0010);
      apply(1'b0, 1'b0, 4'b0100);
      apply(1'b0, 1'b0, 4'b1000);
      apply(1'b0, 1'b0, 4'b0000);
      apply(1'b0, 1'b0, 4'b0000);
    end
    chk("five_errc", d_errc, 8'd5);
    chk("sat_errc", s_errc, 2'd3);
    chk("sat_pulses", sat_pulses, 5);

    // clear on the same edge as a stall fault
    apply(1'b0, 1'b0, 4'b0100);
    apply(1'b0, 1'b0, 4'b1000);
    apply(1'b0, 1'b0, 4'b0001);
    apply(1'b0, 1'b0, 4'b0010);
    chk("pre_stall_locked", d_locked, 1'b1);
    apply(1'b0, 1'b1, 4'b0010);
    chk("clr_fault_errc", d_errc, 8'd1);
    chk("clr_fault_sticky", d_sticky, 1'b1);
    chk("clr_fault_locked", d_locked, 1'b0);

    // relock, plain clear while locked, then reset mid-lock
    apply(1'b0, 1'b0, 4'b0100);
    apply(1'b0, 1'b0, 4'b1000);
    apply(1'b0, 1'b0, 4'b0001);
    apply(1'b0, 1'b0, 4'b0010);
    apply(1'b0, 1'b0, 4'b0100);
    chk("relock", d_locked, 1'b1);
    apply(1'b0, 1'b1, 4'b1000);
    chk("clr_alone_errc", d_errc, 8'd0);
    chk("clr_alone_sticky", d_sticky, 1'b0);
    apply(1'b1, 1'b0, 4'b0001);
    chk("rst_all", {d_locked, d_phase, d_wrap, d_rev, d_errp, d_sticky, d_errc}, 32'd0);

    // random traffic: mostly clean rotation with holds, skips, reversals, garbage
    tok = 0;
    for (int i = 0; i < 800; i++) begin
      rs = ($urandom_range(0, 199) == 0);
      cl = ($urandom_range(0, 39) == 0);
      n  = $urandom_range(0, 19);
      if (n < 15) begin
        tok = (tok + 1) % W;
        v = 4'(1 << tok);
      end else if (n == 15) begin
        v = 4'($urandom);
      end else if (n == 16) begin
        v = 4'(1 << tok);
      end else if (n == 17) begin
        tok = (tok + W - 1) % W;
        v = 4'(1 << tok);
      end else if (n == 18) begin
        tok = (tok + 2) % W;
        v = 4'(1 << tok);
      end else begin
        v = 4'b0000;
      end
      apply(rs, cl, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
